instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned reads to instruction memory
// and buffers returned words with their PCs in a 2-entry queue.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   redirect            - taken branch/jump; flushes queue, reloads fetch PC
//   redirect_pc         - new fetch address (low two bits ignored)
//   imem_req/imem_addr  - registered memory read request and address
//   imem_ack/imem_rdata - memory response strobe and data
//   inst_valid/inst/inst_pc - queue head
//   inst_ready          - consumer accepts the queue head
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DISCARD
   } state_t;

   localparam logic [1:0] CNT_MAX = QDEPTH[1:0];

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  count_q, count_d;
   logic        wptr_q, wptr_d;
   logic        rptr_q, rptr_d;
   logic [31:0] inst_mem_q [2];
   logic [31:0] pc_mem_q [2];

   logic        pop;
   logic        push;
   logic [1:0]  cnt_pop;
   logic [1:0]  cnt_post;
   logic [31:0] redir_pc;
   logic [31:0] addr_inc;

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst       = inst_mem_q[rptr_q];
   assign inst_pc    = pc_mem_q[rptr_q];

   // Redirect wins over everything: a same-cycle pop or push is discarded.
   assign pop      = inst_valid & inst_ready & ~redirect;
   assign push     = (state_q == BUSY) & imem_ack & ~redirect;
   assign cnt_pop  = count_q - {1'b0, pop};
   assign cnt_post = cnt_pop + {1'b0, push};
   assign redir_pc = {redirect_pc[31:2], 2'b00};
   assign addr_inc = addr_q + 32'd4;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      count_d    = cnt_post;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;

      if (redirect) begin
         count_d    = 2'd0;
         wptr_d     = 1'b0;
         rptr_d     = 1'b0;
         fetch_pc_d = redir_pc;
      end else begin
         if (pop)
            rptr_d = ~rptr_q;
         if (push)
            wptr_d = ~wptr_q;
      end

      unique case (state_q)
         IDLE: begin
            if (!redirect && (cnt_pop < CNT_MAX)) begin
               state_d = BUSY;
               req_d   = 1'b1;
               addr_d  = fetch_pc_q;
            end
         end
         BUSY: begin
            if (redirect) begin
               // An outstanding request cannot be abandoned; its data is
               // dropped later in DISCARD.
               if (imem_ack) begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end else begin
                  state_d = DISCARD;
               end
            end else if (imem_ack) begin
               fetch_pc_d = addr_inc;
               if (cnt_post < CNT_MAX) begin
                  addr_d = addr_inc;
               end else begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end
         end
         DISCARD: begin
            if (imem_ack) begin
               state_d = BUSY;
               req_d   = 1'b1;
               addr_d  = fetch_pc_d;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         count_q    <= 2'd0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_mem_q[0] <= 32'd0;
         inst_mem_q[1] <= 32'd0;
         pc_mem_q[0]   <= 32'd0;
         pc_mem_q[1]   <= 32'd0;
      end else if (push) begin
         inst_mem_q[wptr_q] <= imem_rdata;
         pc_mem_q[wptr_q]   <= addr_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: zero-wait fetch, backpressure,
// redirect during wait, redirect with full queue, wrap, async reset.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic        imem_ack, imem_ack2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        inst_valid, inst_valid2;
   logic [31:0] inst, inst2;
   logic [31:0] inst_pc, inst_pc2;
   logic        inst_ready;
   logic        zw;
   logic        ack_man;

   int checks = 0;
   int errors = 0;

   assign imem_ack    = zw ? imem_req : ack_man;
   assign imem_rdata  = ~imem_addr;
   assign imem_ack2   = imem_req2;
   assign imem_rdata2 = ~imem_addr2;

   instr_fetch dut (
      .clk(clk), .rst(rst),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
      .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
      .inst_ready(inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'd0;
      inst_ready = 1'b1;
      zw = 1'b1;
      ack_man = 1'b0;

      // Reset state and zero-wait streaming, plus wrap on dut2
      tick();
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
      rst = 1'b0;
      tick();
      chk("zw_req1", {31'd0, imem_req}, 32'd1);
      chk("zw_addr1", imem_addr, 32'd0);
      chk("zw_valid1", {31'd0, inst_valid}, 32'd0);
      chk("zw_addr2", imem_addr2, 32'hFFFF_FFF8);
      tick();
      chk("zw_valid2", {31'd0, inst_valid}, 32'd1);
      chk("zw_pc0", inst_pc, 32'd0);
      chk("zw_inst0", inst, 32'hFFFF_FFFF);
      chk("wrap_pc0", inst_pc2, 32'hFFFF_FFF8);
      tick();
      chk("zw_pc4", inst_pc, 32'd4);
      chk("wrap_pc1", inst_pc2, 32'hFFFF_FFFC);
      tick();
      chk("zw_pc8", inst_pc, 32'd8);
      chk("wrap_pc2", inst_pc2, 32'h0000_0000);
      chk("wrap_inst2", inst2, 32'hFFFF_FFFF);
      tick();
      chk("zw_pc12", inst_pc, 32'd12);
      chk("zw_inst12", inst, ~32'd12);

      // Backpressure: queue fills, request stops, order preserved
      rst = 1'b1;
      inst_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("bp_pc0a", inst_pc, 32'd0);
      tick();
      chk("bp_req_off", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_pc0b", inst_pc, 32'd0);
      tick();
      chk("bp_req_off2", {31'd0, imem_req}, 32'd0);
      chk("bp_pc0c", inst_pc, 32'd0);
      inst_ready = 1'b1;
      tick();
      chk("bp_pc4", inst_pc, 32'd4);
      chk("bp_req_on", {31'd0, imem_req}, 32'd1);
      chk("bp_addr8", imem_addr, 32'd8);
      tick();
      chk("bp_pc8", inst_pc, 32'd8);
      chk("bp_inst8", inst, ~32'd8);

      // Redirect while a slow request is outstanding
      rst = 1'b1;
      zw = 1'b0;
      ack_man = 1'b0;
      inst_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("sl_addr0", imem_addr, 32'd0);
      ack_man = 1'b1;
      tick();
      tick();
      chk("sl_addr8", imem_addr, 32'd8);
      chk("sl_pc4", inst_pc, 32'd4);
      ack_man = 1'b0;
      tick();
      chk("sl_hold1", imem_addr, 32'd8);
      chk("sl_valid0", {31'd0, inst_valid}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      chk("sl_hold2", imem_addr, 32'd8);
      chk("sl_req_hold", {31'd0, imem_req}, 32'd1);
      chk("sl_flush", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("sl_hold3", imem_addr, 32'd8);
      ack_man = 1'b1;
      tick();
      chk("sl_req_tgt", {31'd0, imem_req}, 32'd1);
      chk("sl_addr_tgt", imem_addr, 32'h100);
      chk("sl_dropped", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("sl_pc_tgt", inst_pc, 32'h100);
      chk("sl_valid_tgt", {31'd0, inst_valid}, 32'd1);
      ack_man = 1'b0;

      // Redirect with a full queue, unaligned target
      rst = 1'b1;
      zw = 1'b1;
      inst_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("fl_full_valid", {31'd0, inst_valid}, 32'd1);
      chk("fl_full_req", {31'd0, imem_req}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      chk("fl_valid0", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("fl_req", {31'd0, imem_req}, 32'd1);
      chk("fl_addr", imem_addr, 32'h200);
      tick();
      chk("fl_pc", inst_pc, 32'h200);

      // Asynchronous reset during an outstanding request
      rst = 1'b1;
      zw = 1'b0;
      ack_man = 1'b0;
      inst_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("ar_req1", {31'd0, imem_req}, 32'd1);
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      tick();
      chk("ar_pend_addr", imem_addr, 32'd4);
      chk("ar_pend_valid", {31'd0, inst_valid}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_req0", {31'd0, imem_req}, 32'd0);
      chk("ar_valid0", {31'd0, inst_valid}, 32'd0);
      chk("ar_addr", imem_addr, 32'd0);
      chk("ar_pc", inst_pc, 32'd0);
      tick();
      rst = 1'b0;
      zw = 1'b1;
      inst_ready = 1'b1;
      tick();
      chk("ar_restart_req", {31'd0, imem_req}, 32'd1);
      chk("ar_restart_addr", imem_addr, 32'd0);
      tick();
      chk("ar_restart_pc", inst_pc, 32'd0);
      chk("ar_restart_valid", {31'd0, inst_valid}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
